// File: rtl/debouncer_pkg.sv
// Shared constants, state encoding and time conversion for the key debouncer family.
package debouncer_pkg;

  localparam int SYNC_DELAY = 2;

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESSED  = 2'd1,
    HELD     = 2'd2
  } key_state_t;

  // Truncates toward zero so a window never exceeds the requested time.
  function automatic int ns2cycles(input int freq_mhz, input int time_ns);
    return (freq_mhz * time_ns) / 1000;
  endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One push-button: synchroniser, debounce window, press/hold/repeat FSM and registered strobes.
module key_debounce_channel
  import debouncer_pkg::*;
#(
  parameter int GLITCH_CYCLES = 15,
  parameter int HOLD_CYCLES   = 60,
  parameter int REPEAT_CYCLES = 30
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic key_i,
  output logic key_state_o,
  output logic press_stb_o,
  output logic release_stb_o,
  output logic hold_stb_o,
  output logic repeat_stb_o
);

  localparam int REPEAT_MAX = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES : 1;
  localparam int GW = $clog2(GLITCH_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_MAX + 1);

  localparam logic [GW-1:0] GLITCH_LAST = GW'(GLITCH_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX    = HW'(HOLD_CYCLES);
  localparam logic [RW-1:0] REPEAT_LAST = RW'(REPEAT_MAX - 1);

  logic [SYNC_DELAY-1:0] sync_reg;
  key_state_t            state_reg, state_next;
  logic [GW-1:0]         glitch_cnt_reg, glitch_cnt_next;
  logic [HW-1:0]         hold_cnt_reg, hold_cnt_next;
  logic [RW-1:0]         rep_cnt_reg, rep_cnt_next;
  logic                  press_reg, press_next;
  logic                  release_reg, release_next;
  logic                  hold_reg, hold_next;
  logic                  repeat_reg, repeat_next;
  logic                  raw_pressed;
  logic                  stable_pressed;
  logic                  toggle;

  assign raw_pressed    = ~sync_reg[SYNC_DELAY-1];
  assign stable_pressed = (state_reg != RELEASED);

  always_comb begin
    state_next      = state_reg;
    glitch_cnt_next = glitch_cnt_reg;
    hold_cnt_next   = hold_cnt_reg;
    rep_cnt_next    = rep_cnt_reg;
    press_next      = 1'b0;
    release_next    = 1'b0;
    hold_next       = 1'b0;
    repeat_next     = 1'b0;
    toggle          = 1'b0;

    // Any sample agreeing with the stable level restarts the window.
    if (raw_pressed == stable_pressed) begin
      glitch_cnt_next = '0;
    end else if (glitch_cnt_reg == GLITCH_LAST) begin
      glitch_cnt_next = '0;
      toggle          = 1'b1;
    end else begin
      glitch_cnt_next = glitch_cnt_reg + 1'b1;
    end

    case (state_reg)
      RELEASED: begin
        if (toggle) begin
          state_next    = PRESSED;
          press_next    = 1'b1;
          hold_cnt_next = '0;
        end
      end
      PRESSED: begin
        if (toggle) begin
          state_next   = RELEASED;
          release_next = 1'b1;
        end else if (hold_cnt_reg == HOLD_LAST) begin
          state_next    = HELD;
          hold_next     = 1'b1;
          hold_cnt_next = HOLD_MAX;
          rep_cnt_next  = '0;
        end else begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      HELD: begin
        // A release on the same cycle as a repeat terminal count suppresses the repeat.
        if (toggle) begin
          state_next   = RELEASED;
          release_next = 1'b1;
        end else if (REPEAT_CYCLES != 0) begin
          if (rep_cnt_reg == REPEAT_LAST) begin
            repeat_next  = 1'b1;
            rep_cnt_next = '0;
          end else begin
            rep_cnt_next = rep_cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = RELEASED;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_reg       <= '1;
      state_reg      <= RELEASED;
      glitch_cnt_reg <= '0;
      hold_cnt_reg   <= '0;
      rep_cnt_reg    <= '0;
      press_reg      <= 1'b0;
      release_reg    <= 1'b0;
      hold_reg       <= 1'b0;
      repeat_reg     <= 1'b0;
    end else begin
      sync_reg       <= {sync_reg[SYNC_DELAY-2:0], key_i};
      state_reg      <= state_next;
      glitch_cnt_reg <= glitch_cnt_next;
      hold_cnt_reg   <= hold_cnt_next;
      rep_cnt_reg    <= rep_cnt_next;
      press_reg      <= press_next;
      release_reg    <= release_next;
      hold_reg       <= hold_next;
      repeat_reg     <= repeat_next;
    end
  end

  assign key_state_o   = stable_pressed;
  assign press_stb_o   = press_reg;
  assign release_stb_o = release_reg;
  assign hold_stb_o    = hold_reg;
  assign repeat_stb_o  = repeat_reg;

endmodule

// File: rtl/multi_key_debouncer.sv
// KEY_CNT independent active-low button debouncers with press/release/hold/repeat strobes.
module multi_key_debouncer
  import debouncer_pkg::*;
#(
  parameter int CLK_FREQ_MHZ     = 150,
  parameter int GLITCH_TIME_NS   = 100,
  parameter int HOLD_TIME_NS     = 400,
  parameter int REPEAT_PERIOD_NS = 200,
  parameter int KEY_CNT          = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [KEY_CNT-1:0] key_i,
  output logic [KEY_CNT-1:0] key_state_o,
  output logic [KEY_CNT-1:0] press_stb_o,
  output logic [KEY_CNT-1:0] release_stb_o,
  output logic [KEY_CNT-1:0] hold_stb_o,
  output logic [KEY_CNT-1:0] repeat_stb_o
);

  localparam int GLITCH_CYCLES = ns2cycles(CLK_FREQ_MHZ, GLITCH_TIME_NS);
  localparam int HOLD_CYCLES   = ns2cycles(CLK_FREQ_MHZ, HOLD_TIME_NS);
  localparam int REPEAT_CYCLES = ns2cycles(CLK_FREQ_MHZ, REPEAT_PERIOD_NS);

  if (GLITCH_CYCLES < 1) begin : g_chk_glitch
    $error("multi_key_debouncer: GLITCH_CYCLES must be at least 1");
  end
  if (HOLD_CYCLES <= GLITCH_CYCLES) begin : g_chk_hold
    $error("multi_key_debouncer: HOLD_CYCLES must exceed GLITCH_CYCLES");
  end
  if (KEY_CNT < 1) begin : g_chk_keys
    $error("multi_key_debouncer: KEY_CNT must be at least 1");
  end

  for (genvar gi = 0; gi < KEY_CNT; gi++) begin : g_key
    key_debounce_channel #(
      .GLITCH_CYCLES (GLITCH_CYCLES),
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_channel (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .key_i         (key_i[gi]),
      .key_state_o   (key_state_o[gi]),
      .press_stb_o   (press_stb_o[gi]),
      .release_stb_o (release_stb_o[gi]),
      .hold_stb_o    (hold_stb_o[gi]),
      .repeat_stb_o  (repeat_stb_o[gi])
    );
  end

endmodule

// File: tb/tb_multi_key_debouncer.sv
// Self-checking bench: per-cycle reference model, vector table, latency sequences and random bouncing.
module tb_multi_key_debouncer;

  localparam int K = 4;
  localparam int G = 15;
  localparam int H = 60;
  localparam int R = 30;

  logic         clk_i = 1'b0;
  logic         rst_n_i;
  logic [K-1:0] key_i;
  logic [K-1:0] key_state_o, press_stb_o, release_stb_o, hold_stb_o, repeat_stb_o;

  always #5 clk_i = ~clk_i;

  multi_key_debouncer #(
    .CLK_FREQ_MHZ     (150),
    .GLITCH_TIME_NS   (100),
    .HOLD_TIME_NS     (400),
    .REPEAT_PERIOD_NS (200),
    .KEY_CNT          (K)
  ) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .key_i         (key_i),
    .key_state_o   (key_state_o),
    .press_stb_o   (press_stb_o),
    .release_stb_o (release_stb_o),
    .hold_stb_o    (hold_stb_o),
    .repeat_stb_o  (repeat_stb_o)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: raw sample history, run length of disagreeing samples, press timestamps.
  logic [K-1:0] hist[$];
  logic [K-1:0] m_pressed;
  int           m_run[K];
  int           m_press_t[K];
  int           m_t;

  logic [K-1:0] cur_mask;
  int obs_press, obs_release, obs_hold, obs_rep, obs_stray;

  typedef struct {
    logic [K-1:0] mask;
    int           low_len;
    int           exp_press;
    int           exp_release;
    int           exp_hold;
    int           exp_rep;
  } vec_t;

  vec_t vecs[6];

  task automatic check_vec(input string name, input logic [5*K-1:0] act, input logic [5*K-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s edge=%0d got=%h expected=%h", name, m_t, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_pressed = '0;
    m_t = 0;
    for (int k = 0; k < K; k++) begin
      m_run[k]     = 0;
      m_press_t[k] = 0;
    end
  endtask

  task automatic clear_obs();
    obs_press = 0; obs_release = 0; obs_hold = 0; obs_rep = 0; obs_stray = 0;
  endtask

  task automatic tick();
    logic [K-1:0] ep, er, eh, erp, d;
    int e;
    @(posedge clk_i);
    ep = '0; er = '0; eh = '0; erp = '0;
    if (!rst_n_i) begin
      model_reset();
    end else begin
      m_t++;
      hist.push_back(key_i);
      if (hist.size() > 3) void'(hist.pop_front());
      // The debounce logic sees the sample taken two edges earlier.
      d = (hist.size() >= 3) ? hist[hist.size()-3] : '1;
      for (int k = 0; k < K; k++) begin
        if (!d[k] != m_pressed[k]) begin
          m_run[k]++;
          if (m_run[k] == G) begin
            m_run[k]     = 0;
            m_pressed[k] = !d[k];
            if (m_pressed[k]) begin
              ep[k] = 1'b1;
              m_press_t[k] = m_t;
            end else begin
              er[k] = 1'b1;
            end
          end
        end else begin
          m_run[k] = 0;
        end
        if (!ep[k] && !er[k] && m_pressed[k]) begin
          e = m_t - m_press_t[k];
          if (e == H) eh[k] = 1'b1;
          else if (R != 0 && e > H && ((e - H) % R) == 0) erp[k] = 1'b1;
        end
      end
    end
    #1;
    check_vec("cycle", {key_state_o, press_stb_o, release_stb_o, hold_stb_o, repeat_stb_o},
              {m_pressed, ep, er, eh, erp});
    obs_press   += $countones(press_stb_o & cur_mask);
    obs_release += $countones(release_stb_o & cur_mask);
    obs_hold    += $countones(hold_stb_o & cur_mask);
    obs_rep     += $countones(repeat_stb_o & cur_mask);
    obs_stray   += $countones((press_stb_o | release_stb_o | hold_stb_o | repeat_stb_o) & ~cur_mask);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int press_edge, release_edge, p0, p3, remain[K];

    vecs[0] = '{4'b0001,  15, 1, 1, 0, 0};
    vecs[1] = '{4'b0001,  14, 0, 0, 0, 0};
    vecs[2] = '{4'b0001,  16, 1, 1, 0, 0};
    vecs[3] = '{4'b0100, 180, 1, 1, 1, 3};
    vecs[4] = '{4'b1001,  20, 2, 2, 0, 0};
    vecs[5] = '{4'b0010,  80, 1, 1, 1, 0};

    cur_mask = '1;
    clear_obs();
    model_reset();
    rst_n_i = 1'b0;
    key_i   = '1;
    idle(3);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    idle(5);

    // Clean press on key0: 15 low edges, then high.
    key_i[0] = 1'b0;
    press_edge = -1; release_edge = -1;
    for (int i = 1; i <= 45; i++) begin
      tick();
      if (i == 15) key_i[0] = 1'b1;
      if (press_stb_o[0] && press_edge < 0) press_edge = i;
      if (release_stb_o[0] && release_edge < 0) release_edge = i;
    end
    check_int("clean_press_edge", press_edge, 17);
    check_int("clean_release_edge", release_edge, 32);
    $display("[TB] clean press: press edge %0d, release edge %0d", press_edge, release_edge);

    // Bounce on key1, then held low.
    clear_obs();
    for (int r = 0; r < 3; r++) begin
      key_i[1] = 1'b0; idle(3);
      key_i[1] = 1'b1; idle(3);
    end
    check_int("bounce_no_strobe", obs_press + obs_release, 0);
    key_i[1] = 1'b0;
    press_edge = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (press_stb_o[1] && press_edge < 0) press_edge = i;
    end
    check_int("bounce_press_edge", press_edge, 17);
    check_int("bounce_press_count", obs_press, 1);
    $display("[TB] bounce: press edge %0d after final fall", press_edge);
    key_i[1] = 1'b1;
    idle(40);

    // Simultaneous press on keys 0 and 3.
    key_i[0] = 1'b0; key_i[3] = 1'b0;
    p0 = -1; p3 = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (press_stb_o[0] && p0 < 0) p0 = i;
      if (press_stb_o[3] && p3 < 0) p3 = i;
    end
    check_int("simul_key0_edge", p0, 17);
    check_int("simul_key3_edge", p3, 17);
    $display("[TB] simultaneous: key0 edge %0d, key3 edge %0d", p0, p3);
    key_i = '1;
    idle(40);

    // Reset while key2 is in HELD, key kept low through and after reset.
    key_i[2] = 1'b0;
    idle(100);
    #2;
    rst_n_i = 1'b0;
    model_reset();
    #1;
    check_vec("reset_async", {key_state_o, press_stb_o, release_stb_o, hold_stb_o, repeat_stb_o}, '0);
    idle(2);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    press_edge = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (press_stb_o[2] && press_edge < 0) press_edge = i;
    end
    check_int("reset_repress_edge", press_edge, 17);
    $display("[TB] reset mid-hold: re-press edge %0d", press_edge);
    key_i = '1;
    idle(40);

    // Table of single-pulse vectors.
    for (int v = 0; v < 6; v++) begin
      cur_mask = vecs[v].mask;
      clear_obs();
      key_i = ~vecs[v].mask;
      idle(vecs[v].low_len);
      key_i = '1;
      idle(40);
      check_int("vec_press", obs_press, vecs[v].exp_press);
      check_int("vec_release", obs_release, vecs[v].exp_release);
      check_int("vec_hold", obs_hold, vecs[v].exp_hold);
      check_int("vec_repeat", obs_rep, vecs[v].exp_rep);
      check_int("vec_stray", obs_stray, 0);
      $display("[TB] vec %0d mask=%b low=%0d press=%0d release=%0d hold=%0d repeat=%0d stray=%0d",
               v, vecs[v].mask, vecs[v].low_len, obs_press, obs_release, obs_hold, obs_rep, obs_stray);
    end

    // Random bouncing on all keys against the model.
    cur_mask = '1;
    clear_obs();
    for (int k = 0; k < K; k++) remain[k] = $urandom_range(40, 1);
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int k = 0; k < K; k++) begin
        remain[k]--;
        if (remain[k] <= 0) begin
          key_i[k] = ~key_i[k];
          remain[k] = ($urandom_range(3, 0) == 0) ? $urandom_range(150, 20) : $urandom_range(20, 1);
        end
      end
    end
    key_i = '1;
    idle(40);
    $display("[TB] random: press=%0d release=%0d hold=%0d repeat=%0d", obs_press, obs_release, obs_hold, obs_rep);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
